// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its one-step shifter.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ASR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_CLR   = 2'b11;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Combinational single-position shifter: hold, left, right or clear.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] f,
  input  logic             fill_l,
  input  logic             fill_r,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = f;
    case (sel)
      SEL_LEFT:  s = {f[WIDTH-2:0], fill_l};
      SEL_RIGHT: s = {fill_r, f[WIDTH-1:1]};
      SEL_CLR:   s = '0;
      default:   s = f;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller sequencing a one-step shifter to perform N-position
// shifts and rotates; owns the operand register, step counter and op latch.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             serial_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             serial_out
);

  state_e           state, state_nxt;
  op_e              op_q;
  op_e              op_in;
  logic [CNT_W-1:0] counter;
  logic [1:0]       sel;
  logic             fill_l, fill_r;
  logic             out_bit;
  logic [WIDTH-1:0] step_res;

  assign op_in = op_e'(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_in == OP_CLR)                             state_nxt = SHIFT;
          else if (op_in == OP_PASS || op_in == OP_RSVD)   state_nxt = DONE;
          else if (count == '0)                            state_nxt = DONE;
          else                                             state_nxt = SHIFT;
        end
      end
      SHIFT:   if (counter == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Step select, fill bits and the bit leaving the register, all from the latched op.
  always_comb begin
    sel     = SEL_HOLD;
    fill_l  = 1'b0;
    fill_r  = 1'b0;
    out_bit = 1'b0;
    case (op_q)
      OP_SHL: begin sel = SEL_LEFT;  fill_l = serial_in;      out_bit = dout[WIDTH-1]; end
      OP_ROL: begin sel = SEL_LEFT;  fill_l = dout[WIDTH-1];  out_bit = dout[WIDTH-1]; end
      OP_SHR: begin sel = SEL_RIGHT; fill_r = serial_in;      out_bit = dout[0];       end
      OP_ROR: begin sel = SEL_RIGHT; fill_r = dout[0];        out_bit = dout[0];       end
      OP_ASR: begin sel = SEL_RIGHT; fill_r = dout[WIDTH-1];  out_bit = dout[0];       end
      OP_CLR: begin sel = SEL_CLR; end
      default: sel = SEL_HOLD;
    endcase
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .sel    (sel),
    .f      (dout),
    .fill_l (fill_l),
    .fill_r (fill_r),
    .s      (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      serial_out <= 1'b0;
      counter    <= '0;
      op_q       <= OP_PASS;
    end else begin
      case (state)
        IDLE: if (start) begin
          dout       <= din;
          op_q       <= op_in;
          serial_out <= 1'b0;
          counter    <= (op_in == OP_CLR) ? CNT_W'(1) : count;
        end
        SHIFT: begin
          dout       <= step_res;
          serial_out <= out_bit;
          counter    <= counter - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [CNT_W-1:0] count = '0;
  logic [WIDTH-1:0] din = '0;
  logic             serial_in = 1'b0;
  logic             busy, done, serial_out;
  logic [WIDTH-1:0] dout;

  int unsigned checks = 0;
  int unsigned errors = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .count      (count),
    .din        (din),
    .serial_in  (serial_in),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Number of SHIFT cycles an accepted command takes.
  function automatic int steps_for(input int o, input int n);
    case (o)
      0, 7:    return 0;
      6:       return 1;
      default: return n;
    endcase
  endfunction

  // Result of applying n single steps of op o to d, computed as a whole-word operation.
  function automatic void model(input int o, input int n, input logic [WIDTH-1:0] d,
                                input logic s, output logic [WIDTH-1:0] r, output logic so);
    longint unsigned ones, full, ext;
    logic [WIDTH-1:0] rot;
    int k;
    ones = (64'd1 << n) - 64'd1;
    r = d;
    so = 1'b0;
    case (o)
      1: begin
        full = (longint'(d) << n) | (s ? ones : 64'd0);
        r = full[WIDTH-1:0];
        so = (n == 0) ? 1'b0 : full[WIDTH];
      end
      2, 5: begin
        logic f;
        f = (o == 5) ? d[WIDTH-1] : s;
        ext = ((f ? ones : 64'd0) << WIDTH) | longint'(d);
        r = WIDTH'(ext >> n);
        so = (n == 0) ? 1'b0 : 1'((ext >> (n - 1)) & 64'd1);
      end
      3, 4: begin
        k = n % WIDTH;
        if (o == 3) rot = WIDTH'((longint'(d) << k) | (longint'(d) >> (WIDTH - k)));
        else        rot = WIDTH'((longint'(d) >> k) | (longint'(d) << (WIDTH - k)));
        r = rot;
        if (n != 0) so = (o == 3) ? rot[0] : rot[WIDTH-1];
      end
      6: begin
        r = (n == 0) ? d : '0;
        so = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // Issue one command and follow it to completion, checking every cycle.
  task automatic run_op(input int o, input int c, input logic [WIDTH-1:0] d, input logic s);
    int n, busy_cycles;
    logic [WIDTH-1:0] er, final_dout;
    logic eso;
    n = steps_for(o, c);
    @(negedge clk);
    start = 1'b1; op = 3'(o); count = CNT_W'(c); din = d; serial_in = s;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    for (int j = 0; j < 20; j++) begin
      if (done) break;
      model(o, j, d, s, er, eso);
      check("busy", busy, 1'b1);
      check("step_dout", dout, er);
      busy_cycles++;
      start = (j == 3) || ($urandom_range(0, 1) == 1);
      op = 3'($urandom); din = WIDTH'($urandom); count = CNT_W'($urandom);
      @(negedge clk);
    end
    model(o, n, d, s, er, eso);
    check("shift_cycles", busy_cycles, n);
    check("done", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("dout", dout, er);
    check("serial_out", serial_out, eso);
    final_dout = dout;
    start = $urandom_range(0, 1) == 1;
    din = WIDTH'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("dout_hold", dout, final_dout);
    check("serial_hold", serial_out, eso);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_serial", serial_out, 0);
    rst_n = 1'b1;

    run_op(1, 2, 4'b0011, 1'b1);
    run_op(4, 1, 4'b1001, 1'b0);
    run_op(5, 3, 4'b1000, 1'b0);
    run_op(6, 5, 4'b1010, 1'b0);
    run_op(2, 0, 4'b0110, 1'b1);
    run_op(3, 7, 4'b0001, 1'b0);
    run_op(0, 4, 4'b1011, 1'b1);
    run_op(7, 3, 4'b0101, 1'b0);

    // Asynchronous reset in the middle of a rotate.
    @(negedge clk);
    start = 1'b1; op = 3'd3; count = 3'd7; din = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_serial", serial_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 3, 4'b1001, 1'b0);

    for (int i = 0; i < 150; i++)
      run_op($urandom_range(0, 7), $urandom_range(0, 7), WIDTH'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
